// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential Booth multiplier slave.
package mul_pkg;

  // Default operand width; the product is twice this.
  localparam int WIDTH_DEF = 32;

  // Avalon-MM register map.
  localparam logic [1:0] ADDR_A   = 2'd0;
  localparam logic [1:0] ADDR_B   = 2'd1;
  localparam logic [1:0] ADDR_PLO = 2'd2;
  localparam logic [1:0] ADDR_PHI = 2'd3;

  // Engine state: IDLE accepts bus accesses, RUN iterates and stalls them.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mul_booth_step.sv
// One radix-2 Booth iteration: select on the low bit pair, add or subtract
// the multiplicand into the upper half, then arithmetic shift right by one.
module mul_booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] op_a_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0] upper_ext;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] sum;

  // The upper half is widened by one bit so that subtracting the most
  // negative operand cannot wrap; that extra bit becomes the new sign bit
  // after the shift.
  always_comb begin
    upper_ext = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
    a_ext     = {op_a_i[WIDTH-1], op_a_i};
    case (acc_i[1:0])
      2'b01:   sum = upper_ext + a_ext;
      2'b10:   sum = upper_ext - a_ext;
      default: sum = upper_ext;
    endcase
    // Dropping the guard bit and prepending the W+1-bit sum is the shift.
    acc_o = {sum, acc_i[WIDTH:1]};
  end

endmodule

// File: rtl/mul_seq_avalon.sv
// Iterative signed multiplier behind an Avalon-MM slave port.
// Handshake: an access is chipselect & (read | write). waitrequest is high
// whenever an access is presented while the engine is in RUN; the master
// must hold the access unchanged, and it takes effect (with no side effects
// beforehand) on the first rising edge where waitrequest is low.
// Writing address 1 in IDLE latches B and starts WIDTH Booth iterations.
module mul_seq_avalon
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             read,
  input  logic             chipselect,
  output logic [WIDTH-1:0] readdata,
  output logic             waitrequest,
  output mul_state_e       state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               access;
  logic               wr_ok;
  logic [2*WIDTH:0]   acc_step;

  assign access      = chipselect & (read | write);
  assign waitrequest = access & (state_q == ST_RUN);
  assign wr_ok       = chipselect & write & (state_q == ST_IDLE);
  assign state_o     = state_q;

  mul_booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .op_a_i (op_a_q),
    .acc_o  (acc_step)
  );

  // Next-state logic: register writes in IDLE, one Booth step per RUN cycle.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ok) begin
          if (address == ADDR_A) begin
            op_a_d = writedata;
          end else if (address == ADDR_B) begin
            op_b_d  = writedata;
            acc_d   = {{WIDTH{1'b0}}, writedata, 1'b0};
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          prod_d  = acc_step[2*WIDTH:1];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational read mux; zero when no read is presented.
  always_comb begin
    readdata = '0;
    if (chipselect & read) begin
      case (address)
        ADDR_A:   readdata = op_a_q;
        ADDR_B:   readdata = op_b_q;
        ADDR_PLO: readdata = prod_q[WIDTH-1:0];
        ADDR_PHI: readdata = prod_q[2*WIDTH-1:WIDTH];
        default:  readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_avalon.sv
// Self-checking bench for mul_seq_avalon (WIDTH = 32).
module tb_mul_seq_avalon;
  import mul_pkg::*;

  localparam int W = 32;
  localparam int RUN_CYC = 32;

  logic         clk;
  logic         reset;
  logic [1:0]   address;
  logic [W-1:0] writedata;
  logic         write;
  logic         read;
  logic         chipselect;
  logic [W-1:0] readdata;
  logic         waitrequest;
  mul_state_e   state_o;

  int n_cmp;
  int n_err;
  logic [2*W-1:0] exp_q[$];

  mul_seq_avalon #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .writedata   (writedata),
    .write       (write),
    .read        (read),
    .chipselect  (chipselect),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .state_o     (state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed product from plain arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  // Driver: present a write, hold it through waitrequest, count stall cycles.
  task automatic bus_write(input logic [1:0] addr, input logic [W-1:0] data, output int stalls);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = addr; writedata = data;
    stalls = 0;
    #1;
    while (waitrequest === 1'b1 && stalls < 100) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout addr=%0d stalls=%0d required <100", addr, stalls);
    end
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Driver: present a read, hold it through waitrequest, capture data.
  task automatic bus_read(input logic [1:0] addr, output logic [W-1:0] data, output int stalls);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = addr;
    stalls = 0;
    #1;
    while (waitrequest === 1'b1 && stalls < 100) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout addr=%0d stalls=%0d required <100", addr, stalls);
    end
    data = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    int st;
    n_cmp++;
    if (waitrequest !== 1'b0 || readdata !== '0 || state_o !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_outputs wr=%b rd=%h st=%0d required 0/0/IDLE", waitrequest, readdata, state_o);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d, st);
      n_cmp++;
      if (d !== '0 || st !== 0) begin
        n_err++;
        $display("FAIL reset_reg%0d got=%h stalls=%0d required 0/0", i, d, st);
      end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] lo, hi;
    int st;
    bus_write(ADDR_A, 32'd6, st);
    bus_write(ADDR_B, 32'd7, st);
    bus_read(ADDR_PLO, lo, st);
    n_cmp++;
    if (st !== RUN_CYC || lo !== 32'd42) begin
      n_err++;
      $display("FAIL basic_lo got=%0d stalls=%0d required 42/%0d", lo, st, RUN_CYC);
    end
    bus_read(ADDR_PHI, hi, st);
    n_cmp++;
    if (st !== 0 || hi !== 32'd0) begin
      n_err++;
      $display("FAIL basic_hi got=%h stalls=%0d required 0/0", hi, st);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] a_tab [3];
    logic [W-1:0] b_tab [3];
    logic [2*W-1:0] req_tab [3];
    logic [W-1:0] lo, hi;
    int st;
    a_tab[0] = 32'hFFFF_FFFD; b_tab[0] = 32'd5;          req_tab[0] = 64'hFFFF_FFFF_FFFF_FFF1;
    a_tab[1] = 32'h8000_0000; b_tab[1] = 32'h8000_0000; req_tab[1] = 64'h4000_0000_0000_0000;
    a_tab[2] = 32'h8000_0000; b_tab[2] = 32'hFFFF_FFFF; req_tab[2] = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 3; i++) begin
      bus_write(ADDR_A, a_tab[i], st);
      bus_write(ADDR_B, b_tab[i], st);
      bus_read(ADDR_PLO, lo, st);
      bus_read(ADDR_PHI, hi, st);
      n_cmp++;
      if ({hi, lo} !== req_tab[i]) begin
        n_err++;
        $display("FAIL corner%0d got=%h required %h", i, {hi, lo}, req_tab[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d;
    int st;
    bus_write(ADDR_A, 32'd11, st);
    bus_write(ADDR_B, 32'hFFFF_FFFE, st);
    bus_write(ADDR_A, 32'd9, st);
    n_cmp++;
    if (st !== RUN_CYC) begin
      n_err++;
      $display("FAIL stall_write stalls=%0d required %0d", st, RUN_CYC);
    end
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'hFFFF_FFEA || st !== 0) begin
      n_err++;
      $display("FAIL stall_product got=%h stalls=%0d required ffffffea/0", d, st);
    end
    bus_read(ADDR_A, d, st);
    n_cmp++;
    if (d !== 32'd9) begin
      n_err++;
      $display("FAIL stall_op_a got=%0d required 9", d);
    end
    // A stalled read started mid-run waits and sees the new result.
    bus_write(ADDR_B, 32'd3, st);
    repeat (5) @(posedge clk);
    #1;
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'd27 || st !== RUN_CYC - 5) begin
      n_err++;
      $display("FAIL stall_read got=%0d stalls=%0d required 27/%0d", d, st, RUN_CYC - 5);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    int st;
    bus_write(ADDR_A, 32'd5, st);
    bus_write(ADDR_B, 32'd5, st);
    repeat (10) @(posedge clk);
    #1;
    chipselect = 1'b1; read = 1'b1; address = ADDR_PLO;
    #1;
    n_cmp++;
    if (waitrequest !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_busy wr=%b required 1", waitrequest);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (waitrequest !== 1'b0 || readdata !== '0) begin
      n_err++;
      $display("FAIL midrun_reset wr=%b rd=%h required 0/0", waitrequest, readdata);
    end
    chipselect = 1'b0; read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d, st);
      n_cmp++;
      if (d !== '0 || st !== 0) begin
        n_err++;
        $display("FAIL midrun_reg%0d got=%h stalls=%0d required 0/0", i, d, st);
      end
    end
    bus_write(ADDR_A, 32'd2, st);
    bus_write(ADDR_B, 32'd3, st);
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'd6) begin
      n_err++;
      $display("FAIL midrun_after got=%0d required 6", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    int st;
    bus_write(ADDR_A, 32'd1, st);
    bus_write(ADDR_B, 32'd1, st);
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'd1) begin
      n_err++;
      $display("FAIL b2b_first got=%0d required 1", d);
    end
    bus_write(ADDR_A, 32'd4, st);
    bus_write(ADDR_B, 32'd4, st);
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'd16 || st !== RUN_CYC) begin
      n_err++;
      $display("FAIL b2b_second got=%0d stalls=%0d required 16/%0d", d, st, RUN_CYC);
    end
    // A start held through the final step is taken in the first IDLE cycle.
    bus_write(ADDR_A, 32'd3, st);
    bus_write(ADDR_B, 32'd5, st);
    bus_write(ADDR_B, 32'd7, st);
    n_cmp++;
    if (st !== RUN_CYC) begin
      n_err++;
      $display("FAIL b2b_held_start stalls=%0d required %0d", st, RUN_CYC);
    end
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'd21 || st !== RUN_CYC) begin
      n_err++;
      $display("FAIL b2b_held_result got=%0d stalls=%0d required 21/%0d", d, st, RUN_CYC);
    end
  endtask

  task automatic test_no_select();
    logic [W-1:0] d;
    int st;
    chipselect = 1'b0; write = 1'b1; read = 1'b1; address = ADDR_B; writedata = 32'd99;
    #1;
    n_cmp++;
    if (waitrequest !== 1'b0 || readdata !== '0) begin
      n_err++;
      $display("FAIL nosel_outputs wr=%b rd=%h required 0/0", waitrequest, readdata);
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    bus_read(ADDR_B, d, st);
    n_cmp++;
    if (d !== 32'd7 || st !== 0) begin
      n_err++;
      $display("FAIL nosel_op_b got=%0d stalls=%0d required 7/0", d, st);
    end
    bus_read(ADDR_PLO, d, st);
    n_cmp++;
    if (d !== 32'd21 || st !== 0) begin
      n_err++;
      $display("FAIL nosel_prod got=%0d stalls=%0d required 21/0", d, st);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, lo, hi;
    logic [2*W-1:0] exp;
    int st;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 2) a = W'($urandom_range(0, 15)) - W'(8);
      if (i == 3) b = 32'h8000_0000;
      bus_write(ADDR_A, a, st);
      bus_write(ADDR_B, b, st);
      exp_q.push_back(ref_mul(a, b));
      bus_read(ADDR_PLO, lo, st);
      bus_read(ADDR_PHI, hi, st);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({hi, lo} !== exp) begin
        n_err++;
        $display("FAIL random%0d a=%h b=%h got=%h required %h", i, a, b, {hi, lo}, exp);
      end
    end
  endtask

  // Reset, then the scenarios in order, then the report.
  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_no_select();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
